// File: rtl/fp_add_sub_pipe.sv
// Three-stage IEEE-754 add/sub: align, add/normalise, round/pack.
// Valid/ready at both ends; a sideband tag rides along with each op.
module fp_add_sub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_x,
  input  logic [EXP_W+MAN_W:0] in_y,
  input  logic                 operation,
  input  logic [2:0]           round_mode,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_z,
  output logic [4:0]           exceptions,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam int L = MAN_W + 1;
  localparam int N = L + 3;
  localparam int XW = EXP_W + 1;
  localparam int unsigned SH_MAX = MAN_W + 3;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [EXP_W-1:0] EMAX_M1 = EMAX - EXP_W'(1);
  localparam logic [W-1:0] QNAN =
    {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [2:0] RNE = 3'd0;
  localparam logic [2:0] RTZ = 3'd1;
  localparam logic [2:0] RDN = 3'd2;
  localparam logic [2:0] RUP = 3'd3;
  localparam logic [2:0] RMM = 3'd4;

  typedef struct packed {
    logic             sign;
    logic             sub;
    logic [EXP_W-1:0] exp;
    logic [N-1:0]     ma;
    logic [N-1:0]     mb;
    logic [2:0]       rm;
    logic [TAG_W-1:0] tag;
    logic             sp;
    logic [W-1:0]     spz;
    logic             nv;
    logic             zs;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic [XW-1:0]    exp;
    logic [N-1:0]     m;
    logic             zero;
    logic [2:0]       rm;
    logic [TAG_W-1:0] tag;
    logic             sp;
    logic [W-1:0]     spz;
    logic             nv;
    logic             zs;
  } s2_t;

  function automatic int lzc(input logic [N-1:0] v);
    lzc = N;
    for (int i = 0; i < N; i++)
      if (v[i]) lzc = N - 1 - i;
  endfunction

  logic ld1, ld2, ld3;
  logic s1_v, s2_v;
  s1_t  s1, s1_d;
  s2_t  s2, s2_d;

  // ---- stage 1: unpack / classify / align
  logic [EXP_W-1:0] xe, ye, xef, yef, ea, eb, diff;
  logic [MAN_W-1:0] xm, ym;
  logic [L-1:0]     xsig, ysig, sa_sig, sb_sig;
  logic [2*L+1:0]   wide;
  int unsigned      dsh;
  logic xs, ys, swap;
  logic x_zero, y_zero, x_inf, y_inf;
  logic x_nan, y_nan, x_snan, y_snan;

  assign xs = in_x[W-1];
  assign ys = in_y[W-1] ^ operation;
  assign xe = in_x[W-2:MAN_W];
  assign ye = in_y[W-2:MAN_W];
  assign xm = in_x[MAN_W-1:0];
  assign ym = in_y[MAN_W-1:0];

  assign x_zero = (xe == '0) && (xm == '0);
  assign y_zero = (ye == '0) && (ym == '0);
  assign x_inf  = (xe == EMAX) && (xm == '0);
  assign y_inf  = (ye == EMAX) && (ym == '0);
  assign x_nan  = (xe == EMAX) && (xm != '0);
  assign y_nan  = (ye == EMAX) && (ym != '0);
  assign x_snan = x_nan && !xm[MAN_W-1];
  assign y_snan = y_nan && !ym[MAN_W-1];

  // subnormals sit at exponent 1 with no hidden bit
  assign xef  = (xe == '0) ? EXP_W'(1) : xe;
  assign yef  = (ye == '0) ? EXP_W'(1) : ye;
  assign xsig = {xe != '0, xm};
  assign ysig = {ye != '0, ym};

  assign swap   = in_y[W-2:0] > in_x[W-2:0];
  assign ea     = swap ? yef : xef;
  assign eb     = swap ? xef : yef;
  assign sa_sig = swap ? ysig : xsig;
  assign sb_sig = swap ? xsig : ysig;
  assign diff   = ea - eb;
  assign dsh    = (32'(diff) > SH_MAX) ? SH_MAX : 32'(diff);
  assign wide   = {sb_sig, {(L+2){1'b0}}} >> dsh;

  always_comb begin
    s1_d      = '0;
    s1_d.sign = swap ? ys : xs;
    s1_d.sub  = xs ^ ys;
    s1_d.exp  = ea;
    s1_d.ma   = {sa_sig, 3'b000};
    s1_d.mb   = {wide[2*L+1:L], |wide[L-1:0]};
    s1_d.rm   = (round_mode > RMM) ? RNE : round_mode;
    s1_d.tag  = in_tag;
    s1_d.zs   = (x_zero && y_zero && xs == ys) ?
                xs : (s1_d.rm == RDN);
    if (x_snan || y_snan) begin
      s1_d.sp  = 1'b1;
      s1_d.spz = QNAN;
      s1_d.nv  = 1'b1;
    end else if (x_nan || y_nan) begin
      s1_d.sp  = 1'b1;
      s1_d.spz = QNAN;
    end else if (x_inf && y_inf) begin
      s1_d.sp  = 1'b1;
      s1_d.nv  = (xs != ys);
      s1_d.spz = (xs == ys) ?
                 {xs, EMAX, {MAN_W{1'b0}}} : QNAN;
    end else if (x_inf) begin
      s1_d.sp  = 1'b1;
      s1_d.spz = {xs, EMAX, {MAN_W{1'b0}}};
    end else if (y_inf) begin
      s1_d.sp  = 1'b1;
      s1_d.spz = {ys, EMAX, {MAN_W{1'b0}}};
    end
  end

  // ---- stage 2: add / normalise
  logic [N:0]    sum;
  logic [XW-1:0] e1;
  int            lz, lim, shl;

  always_comb begin
    e1   = {1'b0, s1.exp};
    sum  = s1.sub ? ({1'b0, s1.ma} - {1'b0, s1.mb})
                  : ({1'b0, s1.ma} + {1'b0, s1.mb});
    lz   = lzc(sum[N-1:0]);
    lim  = int'(e1) - 1;
    // never push the exponent below 1: leaves a subnormal
    shl  = (lz < lim) ? lz : lim;
    s2_d      = '0;
    s2_d.sign = s1.sign;
    s2_d.zero = (sum == '0);
    s2_d.rm   = s1.rm;
    s2_d.tag  = s1.tag;
    s2_d.sp   = s1.sp;
    s2_d.spz  = s1.spz;
    s2_d.nv   = s1.nv;
    s2_d.zs   = s1.zs;
    if (sum[N]) begin
      s2_d.m   = {sum[N:2], |sum[1:0]};
      s2_d.exp = e1 + XW'(1);
    end else begin
      s2_d.m   = sum[N-1:0] << shl;
      s2_d.exp = e1 - XW'(shl);
    end
  end

  // ---- stage 3: round / pack
  logic [L-1:0]  sig, mant;
  logic [L:0]    sr;
  logic [XW-1:0] ee;
  logic [W-1:0]  z3;
  logic [4:0]    f3;
  logic g, rs, nx, inc, big, ovf;

  always_comb begin
    sig = s2.m[N-1:3];
    g   = s2.m[2];
    rs  = |s2.m[1:0];
    nx  = g | rs;
    inc = 1'b0;
    big = 1'b1;
    unique case (s2.rm)
      RTZ: begin
        inc = 1'b0;
        big = 1'b0;
      end
      RDN: begin
        inc = nx & s2.sign;
        big = s2.sign;
      end
      RUP: begin
        inc = nx & ~s2.sign;
        big = ~s2.sign;
      end
      RMM: begin
        inc = g;
        big = 1'b1;
      end
      default: begin
        inc = g & (rs | sig[0]);
        big = 1'b1;
      end
    endcase
    sr   = {1'b0, sig} + {{L{1'b0}}, inc};
    mant = sr[L] ? sr[L:1] : sr[L-1:0];
    ee   = sr[L] ? s2.exp + XW'(1) : s2.exp;
    ovf  = ee >= {1'b0, EMAX};
    z3   = {s2.sign,
            mant[L-1] ? ee[EXP_W-1:0] : {EXP_W{1'b0}},
            mant[MAN_W-1:0]};
    f3   = {3'b000, ~mant[L-1] & nx, nx};
    if (s2.sp) begin
      z3 = s2.spz;
      f3 = {s2.nv, 4'b0000};
    end else if (s2.zero) begin
      z3 = {s2.zs, {(W-1){1'b0}}};
      f3 = '0;
    end else if (ovf) begin
      f3 = 5'b00101;
      z3 = big ? {s2.sign, EMAX, {MAN_W{1'b0}}}
               : {s2.sign, EMAX_M1, {MAN_W{1'b1}}};
    end
  end

  // ---- handshake: a stage loads when the next is free or draining
  assign ld3      = !out_valid || out_ready;
  assign ld2      = !s2_v || ld3;
  assign ld1      = !s1_v || ld2;
  assign in_ready = ld1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v       <= 1'b0;
      s2_v       <= 1'b0;
      out_valid  <= 1'b0;
      s1         <= '0;
      s2         <= '0;
      out_z      <= '0;
      exceptions <= '0;
      out_tag    <= '0;
    end else begin
      if (ld1) begin
        s1_v <= in_valid;
        if (in_valid) s1 <= s1_d;
      end
      if (ld2) begin
        s2_v <= s1_v;
        if (s1_v) s2 <= s2_d;
      end
      if (ld3) begin
        out_valid <= s2_v;
        if (s2_v) begin
          out_z      <= z3;
          exceptions <= f3;
          out_tag    <= s2.tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// Scoreboard bench for fp_add_sub_pipe: directed vectors,
// backpressure ordering and mid-stream reset.
module tb_fp_add_sub_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_x = '0;
  logic [31:0] in_y = '0;
  logic        operation = 1'b0;
  logic [2:0]  round_mode = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_z;
  logic [4:0]  exceptions;
  logic [3:0]  out_tag;

  fp_add_sub_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y),
    .operation(operation), .round_mode(round_mode),
    .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .exceptions(exceptions),
    .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] z;
    logic [4:0]  f;
    logic [3:0]  tag;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [3:0]  t = '0;
  logic [31:0] z_hold;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, req, $time);
    end
  endtask

  // monitor: compare every output handshake against the queue head
  initial forever begin
    @(negedge clk);
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("stale_out", out_valid, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("z", out_z, e.z);
        check("flags", exceptions, e.f);
        check("tag", out_tag, e.tag);
        if (e.lat) check("latency", cyc - e.cyc, 3);
      end
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y,
                      input logic op, input logic [2:0] rm,
                      input logic [31:0] z, input logic [4:0] f,
                      input bit lat, input bit rdy);
    exp_t e;
    @(negedge clk);
    in_valid   = 1'b1;
    in_x       = x;
    in_y       = y;
    operation  = op;
    round_mode = rm;
    in_tag     = t;
    #1;
    if (rdy) check("no_bubble_ready", in_ready, 1);
    for (int i = 0; i < 100 && !in_ready; i++) begin
      @(negedge clk);
      #1;
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    e = '{z, f, t, cyc, lat};
    sb.push_back(e);
    t = t + 4'd1;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 50 && sb.size() > 0; i++)
      @(negedge clk);
    check("drained", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_z", out_z, 0);
    check("rst_exc", exceptions, 0);
    check("rst_out_tag", out_tag, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic arithmetic, zero signs, specials, rounding, overflow
    send(32'h3F800000, 32'h3F800000, 0, 3'd0, 32'h40000000, 5'b00000, 1, 0);
    send(32'h40000000, 32'h3F800000, 1, 3'd0, 32'h3F800000, 5'b00000, 1, 0);
    send(32'hBF800000, 32'h3F800000, 1, 3'd0, 32'hC0000000, 5'b00000, 1, 0);
    send(32'h3F800000, 32'h3F800000, 1, 3'd0, 32'h00000000, 5'b00000, 1, 0);
    send(32'h3F800000, 32'h3F800000, 1, 3'd2, 32'h80000000, 5'b00000, 1, 0);
    send(32'h3F800000, 32'h00000000, 0, 3'd0, 32'h3F800000, 5'b00000, 1, 0);
    send(32'h7F800000, 32'h3F800000, 0, 3'd0, 32'h7F800000, 5'b00000, 1, 0);
    send(32'h7FC00000, 32'h3F800000, 0, 3'd0, 32'h7FC00000, 5'b00000, 1, 0);
    send(32'h7F800001, 32'h3F800000, 0, 3'd0, 32'h7FC00000, 5'b10000, 1, 0);
    send(32'h7F800000, 32'h7F800000, 1, 3'd0, 32'h7FC00000, 5'b10000, 1, 0);
    send(32'h00400000, 32'h3F800000, 0, 3'd0, 32'h3F800000, 5'b00001, 1, 0);
    send(32'h7F7FFFFF, 32'h3F7FFFFF, 0, 3'd0, 32'h7F7FFFFF, 5'b00001, 1, 0);
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 0, 3'd0, 32'h7F800000, 5'b00101, 1, 0);
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 0, 3'd1, 32'h7F7FFFFF, 5'b00101, 1, 0);
    send(32'hFF7FFFFF, 32'hFF7FFFFF, 0, 3'd2, 32'hFF800000, 5'b00101, 1, 0);
    send(32'hFF7FFFFF, 32'hFF7FFFFF, 0, 3'd3, 32'hFF7FFFFF, 5'b00101, 1, 0);
    send(32'h3F800000, 32'h00000001, 0, 3'd3, 32'h3F800001, 5'b00001, 1, 0);
    send(32'hBF800000, 32'h80000001, 0, 3'd2, 32'hBF800001, 5'b00001, 1, 0);
    send(32'h3F800000, 32'h33800000, 0, 3'd0, 32'h3F800000, 5'b00001, 1, 0);
    send(32'h3F800000, 32'h33800000, 0, 3'd4, 32'h3F800001, 5'b00001, 1, 0);
    send(32'h3F800000, 32'h33800000, 0, 3'd7, 32'h3F800000, 5'b00001, 1, 0);
    send(32'h00000001, 32'h00000001, 0, 3'd0, 32'h00000002, 5'b00000, 1, 0);
    send(32'h00400000, 32'h00400000, 0, 3'd0, 32'h00800000, 5'b00000, 1, 0);
    idle();
    wait_empty();

    // backpressure: three accepts fill the pipe, then drain in order
    t = '0;
    @(negedge clk);
    out_ready = 1'b0;
    send(32'h3F800000, 32'h3F800000, 0, 3'd0, 32'h40000000, 5'b0, 0, 0);
    send(32'h40000000, 32'h40000000, 0, 3'd0, 32'h40800000, 5'b0, 0, 0);
    send(32'h40000000, 32'h3F800000, 0, 3'd0, 32'h40400000, 5'b0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("full_after_3", in_ready, 0);
    z_hold = out_z;
    repeat (4) begin
      @(negedge clk);
      #1;
      check("stall_valid", out_valid, 1);
      check("stall_hold", out_z, z_hold);
      check("stall_tag", out_tag, 0);
      check("stall_full", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h40800000, 32'h40800000, 0, 3'd0, 32'h41000000, 5'b0, 0, 1);
    send(32'h3F800000, 32'h3F800000, 1, 3'd0, 32'h00000000, 5'b0, 0, 0);
    send(32'h40800000, 32'h40000000, 1, 3'd0, 32'h40000000, 5'b0, 0, 0);
    idle();
    wait_empty();

    // reset with results in flight
    @(negedge clk);
    out_ready = 1'b0;
    send(32'h3F800000, 32'h3F800000, 0, 3'd0, 32'h40000000, 5'b0, 0, 0);
    send(32'h40000000, 32'h3F800000, 0, 3'd0, 32'h40400000, 5'b0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    check("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_z", out_z, 0);
    check("mid_rst_out_tag", out_tag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    send(32'h40400000, 32'h3F800000, 0, 3'd0, 32'h40800000, 5'b0, 1, 0);
    idle();
    wait_empty();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
